id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe_pkg.sv | 31 +++
 rtl/id_ex_pipe_load_use_detect.sv | 34 +++
 rtl/id_ex_pipe.sv | 158 +++++++++++++++
 tb/tb_id_ex_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg
//   Shared widths, ALU opcode encodings and the field values loaded into the
//   ID/EX register when a bubble (NOP) is inserted.
package id_ex_pipe_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef enum logic [3:0] {
        ALU_NOP = 4'h0,
        ALU_ADD = 4'h1,
        ALU_SUB = 4'h2,
        ALU_AND = 4'h3,
        ALU_OR  = 4'h4,
        ALU_XOR = 4'h5,
        ALU_SLL = 4'h6,
        ALU_SRL = 4'h7,
        ALU_SLT = 4'h8,
        ALU_LUI = 4'h9
    } alu_op_e;

    // Bubble contents: an invalid instruction that writes nothing.
    localparam logic       BUBBLE_VALID    = 1'b0;
    localparam logic       BUBBLE_WRITEREG = 1'b0;
    localparam logic       BUBBLE_MEMREAD  = 1'b0;
    localparam logic       BUBBLE_MEMWRITE = 1'b0;
    localparam logic [3:0] BUBBLE_ALUOP    = ALU_NOP;

    localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// load_use_detect
//   Combinational load-use hazard check between the instruction in EX and
//   the one in ID.
//   Inputs : EX-side load description, ID-side source usage, hold, flush.
//   Output : stall - freeze PC and IF/ID, insert a bubble into EX.
module load_use_detect #(
    parameter int REG_W = 4
) (
    input  logic             ex_valid,
    input  logic             ex_MemRead,
    input  logic             ex_WriteReg,
    input  logic [REG_W-1:0] ex_DstReg,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_SrcReg1,
    input  logic [REG_W-1:0] id_SrcReg2,
    input  logic             id_Uses1,
    input  logic             id_Uses2,
    input  logic             hold,
    input  logic             flush,
    output logic             stall
);

    logic load_in_ex;
    logic src_match;

    // R0 loads never create a dependency: the write is discarded anyway.
    assign load_in_ex = ex_valid & ex_MemRead & ex_WriteReg & (ex_DstReg != '0);
    assign src_match  = (id_Uses1 & (id_SrcReg1 == ex_DstReg)) |
                        (id_Uses2 & (id_SrcReg2 == ex_DstReg));

    // While frozen or flushing, the ID instruction is not advancing anyway.
    assign stall = load_in_ex & id_valid & src_match & ~hold & ~flush;

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe
//   ID/EX pipeline register with load-use bubble insertion.
//   clk, rst (sync, active-high), hold (freeze EX), flush (kill ID instr)
//   id_*  : decoded instruction in ID
//   ex_*  : registered instruction in EX
//   stall_id     : combinational, PC and IF/ID must hold this cycle
//   bubble_count : saturating count of load-use bubbles inserted
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int DATA_W = id_ex_pipe_pkg::DATA_W,
    parameter int REG_W  = id_ex_pipe_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_SrcReg1,
    input  logic [REG_W-1:0]  id_SrcReg2,
    input  logic              id_Uses1,
    input  logic              id_Uses2,
    input  logic [DATA_W-1:0] id_SrcData1,
    input  logic [DATA_W-1:0] id_SrcData2,
    input  logic [REG_W-1:0]  id_DstReg,
    input  logic              id_WriteReg,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic [3:0]        id_AluOp,
    input  logic [DATA_W-1:0] id_Imm,
    output logic [REG_W-1:0]  ex_SrcReg1,
    output logic [REG_W-1:0]  ex_SrcReg2,
    output logic [DATA_W-1:0] ex_SrcData1,
    output logic [DATA_W-1:0] ex_SrcData2,
    output logic [REG_W-1:0]  ex_DstReg,
    output logic              ex_WriteReg,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic [3:0]        ex_AluOp,
    output logic [DATA_W-1:0] ex_Imm,
    output logic              ex_valid,
    output logic              stall_id,
    output logic [15:0]       bubble_count
);

    logic [REG_W-1:0]  src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
    logic              wr_q, wr_d, mrd_q, mrd_d, mwr_q, mwr_d, vld_q, vld_d;
    logic [3:0]        alu_q, alu_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              stall;

    load_use_detect #(.REG_W(REG_W)) u_detect (
        .ex_valid   (vld_q),
        .ex_MemRead (mrd_q),
        .ex_WriteReg(wr_q),
        .ex_DstReg  (dst_q),
        .id_valid   (id_valid),
        .id_SrcReg1 (id_SrcReg1),
        .id_SrcReg2 (id_SrcReg2),
        .id_Uses1   (id_Uses1),
        .id_Uses2   (id_Uses2),
        .hold       (hold),
        .flush      (flush),
        .stall      (stall)
    );

    always_comb begin
        src1_d  = src1_q;
        src2_d  = src2_q;
        data1_d = data1_q;
        data2_d = data2_q;
        dst_d   = dst_q;
        wr_d    = wr_q;
        mrd_d   = mrd_q;
        mwr_d   = mwr_q;
        alu_d   = alu_q;
        imm_d   = imm_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        if (hold) begin
            // Freeze: everything keeps its value, flush waits for hold to drop.
        end else if (flush || stall) begin
            src1_d  = '0;
            src2_d  = '0;
            data1_d = '0;
            data2_d = '0;
            dst_d   = '0;
            wr_d    = BUBBLE_WRITEREG;
            mrd_d   = BUBBLE_MEMREAD;
            mwr_d   = BUBBLE_MEMWRITE;
            alu_d   = BUBBLE_ALUOP;
            imm_d   = '0;
            vld_d   = BUBBLE_VALID;
            // stall is already masked by flush, so a flush never counts.
            if (stall && cnt_q != BUBBLE_CNT_MAX)
                cnt_d = cnt_q + 16'd1;
        end else begin
            src1_d  = id_SrcReg1;
            src2_d  = id_SrcReg2;
            data1_d = id_SrcData1;
            data2_d = id_SrcData2;
            dst_d   = id_DstReg;
            // Writes to R0 are dropped here so later hazard logic ignores them.
            wr_d    = id_valid & id_WriteReg & (id_DstReg != '0);
            mrd_d   = id_valid & id_MemRead;
            mwr_d   = id_valid & id_MemWrite;
            alu_d   = id_AluOp;
            imm_d   = id_Imm;
            vld_d   = id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src1_q  <= '0;
            src2_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
            dst_q   <= '0;
            wr_q    <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            alu_q   <= '0;
            imm_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            dst_q   <= dst_d;
            wr_q    <= wr_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            alu_q   <= alu_d;
            imm_q   <= imm_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_SrcReg1   = src1_q;
    assign ex_SrcReg2   = src2_q;
    assign ex_SrcData1  = data1_q;
    assign ex_SrcData2  = data2_q;
    assign ex_DstReg    = dst_q;
    assign ex_WriteReg  = wr_q;
    assign ex_MemRead   = mrd_q;
    assign ex_MemWrite  = mwr_q;
    assign ex_AluOp     = alu_q;
    assign ex_Imm       = imm_q;
    assign ex_valid     = vld_q;
    assign stall_id     = stall;
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe
//   Randomized plus directed stimulus against a behavioural model of the
//   ID/EX register; outputs compared on every falling edge.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst, hold, flush, id_valid;
    logic [3:0]  id_SrcReg1, id_SrcReg2, id_DstReg, id_AluOp;
    logic        id_Uses1, id_Uses2, id_WriteReg, id_MemRead, id_MemWrite;
    logic [15:0] id_SrcData1, id_SrcData2, id_Imm;
    logic [3:0]  ex_SrcReg1, ex_SrcReg2, ex_DstReg, ex_AluOp;
    logic [15:0] ex_SrcData1, ex_SrcData2, ex_Imm, bubble_count;
    logic        ex_WriteReg, ex_MemRead, ex_MemWrite, ex_valid, stall_id;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_SrcReg1(id_SrcReg1), .id_SrcReg2(id_SrcReg2),
        .id_Uses1(id_Uses1), .id_Uses2(id_Uses2),
        .id_SrcData1(id_SrcData1), .id_SrcData2(id_SrcData2),
        .id_DstReg(id_DstReg), .id_WriteReg(id_WriteReg),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_AluOp(id_AluOp), .id_Imm(id_Imm),
        .ex_SrcReg1(ex_SrcReg1), .ex_SrcReg2(ex_SrcReg2),
        .ex_SrcData1(ex_SrcData1), .ex_SrcData2(ex_SrcData2),
        .ex_DstReg(ex_DstReg), .ex_WriteReg(ex_WriteReg),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_AluOp(ex_AluOp), .ex_Imm(ex_Imm), .ex_valid(ex_valid),
        .stall_id(stall_id), .bubble_count(bubble_count)
    );

    // Behavioural model: one record for the instruction sitting in EX.
    typedef struct {
        int  s1, s2, d1, d2, dst, alu, imm;
        bit  wr, mr, mw, vld;
    } instr_t;

    instr_t m_ex;
    int     m_cnt;

    function automatic instr_t nop();
        instr_t n;
        n.s1 = 0; n.s2 = 0; n.d1 = 0; n.d2 = 0; n.dst = 0; n.alu = 0; n.imm = 0;
        n.wr = 0; n.mr = 0; n.mw = 0; n.vld = 0;
        return n;
    endfunction

    // A real load into a non-zero register that the ID instruction reads.
    function automatic bit m_stall();
        bit load, dep;
        load = m_ex.vld && m_ex.mr && m_ex.wr && m_ex.dst != 0;
        dep  = (id_Uses1 && int'(id_SrcReg1) == m_ex.dst) ||
               (id_Uses2 && int'(id_SrcReg2) == m_ex.dst);
        return load && dep && id_valid && !hold && !flush;
    endfunction

    initial begin
        m_ex  = nop();
        m_cnt = 0;
    end

    always @(posedge clk) begin
        instr_t c;
        if (rst) begin
            m_ex  = nop();
            m_cnt = 0;
        end else if (hold) begin
            // frozen
        end else if (flush) begin
            m_ex = nop();
        end else if (m_stall()) begin
            m_ex  = nop();
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end else begin
            c.s1  = id_SrcReg1;  c.s2 = id_SrcReg2;
            c.d1  = id_SrcData1; c.d2 = id_SrcData2;
            c.dst = id_DstReg;   c.alu = id_AluOp; c.imm = id_Imm;
            c.vld = id_valid;
            c.wr  = id_valid && id_WriteReg && id_DstReg != 0;
            c.mr  = id_valid && id_MemRead;
            c.mw  = id_valid && id_MemWrite;
            m_ex  = c;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, after the driver has applied inputs.
    always @(negedge clk) begin
        #2;
        chk("stall_id",     32'(stall_id),     32'(m_stall()));
        chk("ex_valid",     32'(ex_valid),     32'(m_ex.vld));
        chk("ex_WriteReg",  32'(ex_WriteReg),  32'(m_ex.wr));
        chk("ex_MemRead",   32'(ex_MemRead),   32'(m_ex.mr));
        chk("ex_MemWrite",  32'(ex_MemWrite),  32'(m_ex.mw));
        chk("ex_DstReg",    32'(ex_DstReg),    32'(m_ex.dst));
        chk("ex_SrcReg1",   32'(ex_SrcReg1),   32'(m_ex.s1));
        chk("ex_SrcReg2",   32'(ex_SrcReg2),   32'(m_ex.s2));
        chk("ex_SrcData1",  32'(ex_SrcData1),  32'(m_ex.d1));
        chk("ex_SrcData2",  32'(ex_SrcData2),  32'(m_ex.d2));
        chk("ex_AluOp",     32'(ex_AluOp),     32'(m_ex.alu));
        chk("ex_Imm",       32'(ex_Imm),       32'(m_ex.imm));
        chk("bubble_count", 32'(bubble_count), 32'(m_cnt));
    end

    task automatic set_id(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                          input int dst, input bit wr, input bit mr, input bit mw,
                          input int alu, input int imm);
        id_valid    = v;
        id_SrcReg1  = 4'(s1); id_Uses1 = u1;
        id_SrcReg2  = 4'(s2); id_Uses2 = u2;
        id_SrcData1 = 16'($urandom); id_SrcData2 = 16'($urandom);
        id_DstReg   = 4'(dst); id_WriteReg = wr;
        id_MemRead  = mr; id_MemWrite = mw;
        id_AluOp    = 4'(alu); id_Imm = 16'(imm);
    endtask

    task automatic rand_id();
        set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 15), $urandom);
    endtask

    // Directed-case pin: literal expectation taken just before the next edge.
    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk(nm, act, exp);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        set_id(1, 1, 1, 2, 1, 3, 1, 1, 0, 1, 16'h55AA);

        // Reset for two cycles with a valid instruction present.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        lit("rst_ex_valid", 32'(ex_valid), 0);
        lit("rst_count",    32'(bubble_count), 0);
        lit("rst_stall",    32'(stall_id), 0);
        lit("rst_ex_dst",   32'(ex_DstReg), 0);

        // Load-use: LW R3 then ADD R4,R3,R5.
        @(negedge clk); set_id(1, 1, 1, 0, 0, 3, 1, 1, 0, 1, 16'h0004);
        @(negedge clk); set_id(1, 3, 1, 5, 1, 4, 1, 0, 0, 1, 0);
        #3; lit("lu_stall", 32'(stall_id), 1);
        @(negedge clk); #3;
        lit("lu_bubble_valid", 32'(ex_valid), 0);
        lit("lu_count",        32'(bubble_count), 1);
        lit("lu_no_restall",   32'(stall_id), 0);
        @(negedge clk); #3;
        lit("lu_capture_src1", 32'(ex_SrcReg1), 3);
        lit("lu_capture_vld",  32'(ex_valid), 1);

        // R0: LW R0 never stalls a reader of R0, and WriteReg is dropped.
        @(negedge clk); set_id(1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0);
        @(negedge clk); set_id(1, 0, 1, 0, 1, 2, 1, 0, 0, 1, 0);
        #3;
        lit("r0_stall", 32'(stall_id), 0);
        lit("r0_wr",    32'(ex_WriteReg), 0);

        // Flush and stall together: bubble, no count.
        @(negedge clk); set_id(1, 1, 1, 0, 0, 3, 1, 1, 0, 1, 0);
        @(negedge clk); set_id(1, 3, 1, 0, 0, 4, 1, 0, 0, 1, 0); flush = 1'b1;
        #3; lit("fs_stall", 32'(stall_id), 0);
        @(negedge clk); flush = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        lit("fs_valid", 32'(ex_valid), 0);
        lit("fs_count", 32'(bubble_count), 1);

        // Hold for three cycles with flush pending, then release.
        @(negedge clk); set_id(1, 2, 1, 1, 1, 6, 1, 0, 1, 5, 16'h1234);
        @(negedge clk); hold = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            #3;
            lit("hold_imm", 32'(ex_Imm), 32'h1234);
            lit("hold_alu", 32'(ex_AluOp), 5);
            @(negedge clk);
        end
        hold = 1'b0;
        @(negedge clk); flush = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        lit("hold_flush_valid", 32'(ex_valid), 0);
        lit("hold_flush_imm",   32'(ex_Imm), 0);

        // Saturation: preload the counter, then three load-use stalls.
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        set_id(1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 0);   // LW R1,0(R1)
        repeat (6) @(negedge clk);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3; lit("sat_count", 32'(bubble_count), 32'hFFFF);

        // Random phase; upstream keeps the ID instruction while stalled.
        for (int i = 0; i < 3000; i++) begin
            bit keep;
            keep = m_stall() || hold;
            @(negedge clk);
            rst   = ($urandom_range(0, 199) == 0);
            hold  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 11) == 0);
            if (!keep || $urandom_range(0, 7) == 0) rand_id();
        end

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
